mem_bus_responder: RTL

- CPU-side bus responder completing the path that starts at the address translator.
- Takes the translator's translated address and rom_flag/ram_flag, runs one word access to on-chip ROM or RAM with a fixed number of wait states, and returns read data plus a one-cycle acknowledge to the CPU.
- Unmapped accesses, ROM writes and illegal flag combinations complete with an error acknowledge and do not touch memory.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/wait_counter.sv | 30 +++
 rtl/mem_bus_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions for the responder and the address translator:
// FSM states, memory map constants and the wait-counter width.
package bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ROM_ACC,
      RAM_ACC,
      RESP,
      ERR
   } state_t;

   localparam logic [31:0] ROM_BASE = 32'h0000_0000;
   localparam logic [31:0] ROM_SIZE = 32'h0010_0000;
   localparam logic [31:0] RAM_BASE = 32'h0020_0000;
   localparam logic [31:0] RAM_SIZE = 32'h0080_0000;

   localparam int WAIT_W = 4;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that measures memory wait states; zero marks the
// last access cycle.
module wait_counter
   import bus_pkg::*;
#(
   parameter int W = WAIT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mem_bus_responder.sv
// CPU-side responder: runs one word access to on-chip ROM or RAM with fixed
// wait states and returns registered data plus a one-cycle acknowledge.
module mem_bus_responder
   import bus_pkg::*;
#(
   parameter int ROM_WAIT = 1,
   parameter int RAM_WAIT = 2,
   parameter int ROM_AW   = 18,
   parameter int RAM_AW   = 21
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [3:0]        cpu_be,
   input  logic [31:0]       cpu_wdata,
   input  logic [31:0]       trans_addr,
   input  logic              rom_flag,
   input  logic              ram_flag,
   output logic              cpu_ack,
   output logic              cpu_err,
   output logic [31:0]       cpu_rdata,
   output logic              rom_en,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_rdata,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   state_t              state, next_state;
   logic                acc_we, acc_we_d;
   logic                ack_d, err_d;
   logic [31:0]         rdata_d;
   logic                rom_en_d, ram_en_d;
   logic [ROM_AW-1:0]   rom_addr_d;
   logic [RAM_AW-1:0]   ram_addr_d;
   logic [3:0]          ram_we_d;
   logic [31:0]         ram_wdata_d;
   logic                cnt_load, cnt_dec, cnt_zero;
   logic [WAIT_W-1:0]   cnt_val;

   // Byte offset and bits above the RAM window never affect a word access.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{trans_addr[31:RAM_AW+2], trans_addr[1:0]};

   wait_counter #(.W(WAIT_W)) u_wait (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      next_state  = state;
      acc_we_d    = acc_we;
      ack_d       = 1'b0;
      err_d       = 1'b0;
      rdata_d     = cpu_rdata;
      rom_en_d    = rom_en;
      rom_addr_d  = rom_addr;
      ram_en_d    = ram_en;
      ram_addr_d  = ram_addr;
      ram_we_d    = ram_we;
      ram_wdata_d = ram_wdata;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      cnt_val     = '0;

      unique case (state)
         IDLE: begin
            // The request still held during the ack cycle belongs to the
            // access just completed, so it is not taken again.
            if (cpu_req && !cpu_ack) begin
               acc_we_d = cpu_we;
               if (ram_flag && !rom_flag) begin
                  next_state = RAM_ACC;
                  ram_en_d   = 1'b1;
                  ram_addr_d = trans_addr[RAM_AW+1:2];
                  ram_we_d   = cpu_we ? cpu_be : 4'b0000;
                  if (cpu_we) ram_wdata_d = cpu_wdata;
                  cnt_load   = 1'b1;
                  cnt_val    = WAIT_W'(RAM_WAIT);
               end else if (rom_flag && !ram_flag && !cpu_we) begin
                  next_state = ROM_ACC;
                  rom_en_d   = 1'b1;
                  rom_addr_d = trans_addr[ROM_AW+1:2];
                  cnt_load   = 1'b1;
                  cnt_val    = WAIT_W'(ROM_WAIT);
               end else begin
                  next_state = ERR;
               end
            end
         end
         ROM_ACC: begin
            if (cnt_zero) begin
               rdata_d    = rom_rdata;
               rom_en_d   = 1'b0;
               next_state = RESP;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         RAM_ACC: begin
            if (cnt_zero) begin
               if (!acc_we) rdata_d = ram_rdata;
               ram_en_d   = 1'b0;
               ram_we_d   = 4'b0000;
               next_state = RESP;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         RESP: begin
            ack_d      = 1'b1;
            next_state = IDLE;
         end
         ERR: begin
            ack_d      = 1'b1;
            err_d      = 1'b1;
            rdata_d    = '0;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc_we    <= 1'b0;
         cpu_ack   <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         rom_en    <= 1'b0;
         rom_addr  <= '0;
         ram_en    <= 1'b0;
         ram_we    <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state     <= next_state;
         acc_we    <= acc_we_d;
         cpu_ack   <= ack_d;
         cpu_err   <= err_d;
         cpu_rdata <= rdata_d;
         rom_en    <= rom_en_d;
         rom_addr  <= rom_addr_d;
         ram_en    <= ram_en_d;
         ram_we    <= ram_we_d;
         ram_addr  <= ram_addr_d;
         ram_wdata <= ram_wdata_d;
      end
   end

endmodule
